// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the shared line-wide data memory.
// One transaction at a time: IDLE -> MEM (wait for mem ack) -> LATCH (capture line) -> RESP (ack).
module dmem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LINE_W      = 256,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [LINE_W-1:0] p0_wdata_i,
  output logic              p0_ack_o,
  output logic [LINE_W-1:0] p0_rdata_o,
  input  logic              p1_req_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [LINE_W-1:0] p1_wdata_i,
  output logic              p1_ack_o,
  output logic [LINE_W-1:0] p1_rdata_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              busy_o,
  output logic              grant_o,
  output logic              timeout_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MEM   = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  logic [1:0]        state_q,      state_d;
  logic              grant_q,      grant_d;
  logic              is_write_q,   is_write_d;
  logic              mem_enable_q, mem_enable_d;
  logic              mem_write_q,  mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [LINE_W-1:0] mem_data_q,   mem_data_d;
  logic              p0_ack_q,     p0_ack_d;
  logic              p1_ack_q,     p1_ack_d;
  logic [LINE_W-1:0] p0_rdata_q,   p0_rdata_d;
  logic [LINE_W-1:0] p1_rdata_q,   p1_rdata_d;
  logic              timeout_q,    timeout_d;
  logic [7:0]        timer_q,      timer_d;

  logic              pick_p1;
  logic [7:0]        timer_inc;

  // On a tie the port that did not win last time goes next; grant_q resets to 1 so port 0 wins first.
  assign pick_p1   = (p0_req_i && p1_req_i) ? ~grant_q : p1_req_i;
  assign timer_inc = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;

  always_comb begin
    // NOTE: every next-state signal is defaulted to its current value first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d      = state_q;
    grant_d      = grant_q;
    is_write_d   = is_write_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    p0_ack_d     = 1'b0;
    p1_ack_d     = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    timeout_d    = timeout_q;
    timer_d      = timer_q;

    case (state_q)
      S_IDLE: begin
        if (p0_req_i || p1_req_i) begin
          grant_d      = pick_p1;
          is_write_d   = pick_p1 ? p1_write_i : p0_write_i;
          mem_write_d  = pick_p1 ? p1_write_i : p0_write_i;
          mem_addr_d   = pick_p1 ? p1_addr_i  : p0_addr_i;
          mem_data_d   = pick_p1 ? p1_wdata_i : p0_wdata_i;
          mem_enable_d = 1'b1;
          state_d      = S_MEM;
        end
      end
      S_MEM: begin
        if (mem_ack_i) begin
          mem_enable_d = 1'b0;
          mem_write_d  = 1'b0;
          timer_d      = 8'd0;
          state_d      = S_LATCH;
        end else begin
          // A late memory is flagged but never abandoned; the transaction stays open.
          timer_d = timer_inc;
          if (timer_inc == TIMEOUT_LAST) timeout_d = 1'b1;
        end
      end
      S_LATCH: begin
        if (!is_write_q) begin
          if (grant_q) p1_rdata_d = mem_data_i;
          else         p0_rdata_d = mem_data_i;
        end
        p0_ack_d = ~grant_q;
        p1_ack_d = grant_q;
        state_d  = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b1;
      is_write_q   <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      timeout_q    <= 1'b0;
      timer_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      is_write_q   <= is_write_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      timeout_q    <= timeout_d;
      timer_q      <= timer_d;
    end
  end

  assign p0_ack_o     = p0_ack_q;
  assign p1_ack_o     = p1_ack_q;
  assign p0_rdata_o   = p0_rdata_q;
  assign p1_rdata_o   = p1_rdata_q;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign busy_o       = (state_q != S_IDLE);
  assign grant_o      = grant_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a small line memory model answers grants with chosen latencies.
// Inputs are driven and outputs sampled on the falling edge.
module tb_dmem_arbiter;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         p0_req_i = 1'b0, p0_write_i = 1'b0;
  logic [31:0]  p0_addr_i = '0;
  logic [255:0] p0_wdata_i = '0;
  logic         p0_ack_o;
  logic [255:0] p0_rdata_o;
  logic         p1_req_i = 1'b0, p1_write_i = 1'b0;
  logic [31:0]  p1_addr_i = '0;
  logic [255:0] p1_wdata_i = '0;
  logic         p1_ack_o;
  logic [255:0] p1_rdata_o;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_ack_i = 1'b0;
  logic [255:0] mem_data_i = '0;
  logic         busy_o, grant_o, timeout_o;

  int errors = 0;
  int checks = 0;

  logic [255:0] mem [0:15];
  logic [255:0] p0_saved;
  logic [255:0] a5_line;
  int           w;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .LINE_W(256), .TIMEOUT_CYC(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .p0_req_i(p0_req_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
    .p0_ack_o(p0_ack_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
    .p1_ack_o(p1_ack_o), .p1_rdata_o(p1_rdata_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .busy_o(busy_o), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called on the falling edge where the request was raised; returns on the falling edge of the ack cycle.
  task automatic run_txn(input logic port, input logic wr, input logic [31:0] addr, input int lat,
                         input logic [255:0] wdata, output int waits);
    logic [3:0] idx;
    idx   = addr[8:5];
    waits = 0;
    tick();
    while (!mem_enable_o && waits < 50) begin
      waits++;
      tick();
    end
    chk("grant_enable", {255'd0, mem_enable_o}, 256'd1);
    chk("grant_port", {255'd0, grant_o}, {255'd0, port});
    chk("grant_addr", {224'd0, mem_addr_o}, {224'd0, addr});
    chk("grant_write", {255'd0, mem_write_o}, {255'd0, wr});
    if (wr) chk("grant_wdata", mem_data_o, wdata);
    for (int i = 1; i <= lat; i++) begin
      if (i > 1) tick();
      chk("mem_hold_en", {255'd0, mem_enable_o}, 256'd1);
      chk("mem_hold_addr", {224'd0, mem_addr_o}, {224'd0, addr});
    end
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    chk("latch_en_low", {254'd0, mem_enable_o, mem_write_o}, 256'd0);
    chk("latch_no_ack", {254'd0, p0_ack_o, p1_ack_o}, 256'd0);
    chk("latch_busy", {255'd0, busy_o}, 256'd1);
    if (wr) mem[idx] = wdata;
    mem_data_i = mem[idx];
    tick();
    chk("resp_acks", {254'd0, p0_ack_o, p1_ack_o}, {254'd0, ~port, port});
    if (!wr) chk("resp_rdata", port ? p1_rdata_o : p0_rdata_o, mem[idx]);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = {8{32'hC0DE_0000 | i}};
    a5_line = {32{8'hA5}};

    // Reset state
    tick();
    tick();
    chk("rst_busy", {255'd0, busy_o}, 256'd0);
    chk("rst_grant", {255'd0, grant_o}, 256'd1);
    chk("rst_mem_ctl", {253'd0, mem_enable_o, mem_write_o, timeout_o}, 256'd0);
    chk("rst_mem_addr", {224'd0, mem_addr_o}, 256'd0);
    chk("rst_mem_data", mem_data_o, 256'd0);
    chk("rst_acks", {254'd0, p0_ack_o, p1_ack_o}, 256'd0);
    chk("rst_rdata0", p0_rdata_o, 256'd0);
    chk("rst_rdata1", p1_rdata_o, 256'd0);
    rst_i = 1'b0;
    tick();

    // 1: p0 read 0x40, memory acks in the 12th enable cycle
    p0_addr_i = 32'h40; p0_write_i = 1'b0; p0_req_i = 1'b1;
    run_txn(1'b0, 1'b0, 32'h40, 12, '0, w);
    p0_req_i = 1'b0;
    chk("t1_first_latency", w, 0);
    chk("t1_line2", p0_rdata_o, {8{32'hC0DE_0002}});
    chk("t1_timeout_sticky", {255'd0, timeout_o}, 256'd1);
    tick();
    chk("t1_idle_ack_low", {253'd0, p0_ack_o, p1_ack_o, busy_o}, 256'd0);

    // 2: tie after reset -> p0 then p1; later tie with grant_o=0 -> p1 first
    do_reset();
    p0_addr_i = 32'h00; p1_addr_i = 32'h20; p1_write_i = 1'b0;
    p0_req_i = 1'b1; p1_req_i = 1'b1;
    run_txn(1'b0, 1'b0, 32'h00, 3, '0, w);
    p0_req_i = 1'b0;
    chk("t2_p0_first", w, 0);
    run_txn(1'b1, 1'b0, 32'h20, 2, '0, w);
    p1_req_i = 1'b0;
    chk("t2_p1_after", w, 1);
    tick();
    p0_req_i = 1'b1;
    run_txn(1'b0, 1'b0, 32'h00, 1, '0, w);
    p0_req_i = 1'b0;
    tick();
    p0_req_i = 1'b1; p1_req_i = 1'b1;
    run_txn(1'b1, 1'b0, 32'h20, 2, '0, w);
    p1_req_i = 1'b0;
    chk("t2_rr_p1_first", w, 0);
    run_txn(1'b0, 1'b0, 32'h00, 2, '0, w);
    p0_req_i = 1'b0;
    chk("t2_rr_p0_after", w, 1);

    // 3: p1 write then read back at 0x80; p0 line untouched
    p0_saved = p0_rdata_o;
    tick();
    p1_addr_i = 32'h80; p1_write_i = 1'b1; p1_wdata_i = a5_line; p1_req_i = 1'b1;
    run_txn(1'b1, 1'b1, 32'h80, 3, a5_line, w);
    p1_req_i = 1'b0;
    chk("t3_p0_kept_w", p0_rdata_o, p0_saved);
    tick();
    p1_write_i = 1'b0; p1_wdata_i = '0; p1_req_i = 1'b1;
    run_txn(1'b1, 1'b0, 32'h80, 2, '0, w);
    p1_req_i = 1'b0;
    chk("t3_readback", p1_rdata_o, a5_line);
    chk("t3_p0_kept_r", p0_rdata_o, p0_saved);

    // 4: both requests held high -> grants alternate 0,1,0,1
    tick();
    p0_addr_i = 32'h60; p1_addr_i = 32'hA0;
    p0_req_i = 1'b1; p1_req_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_txn(k[0], 1'b0, k[0] ? 32'hA0 : 32'h60, 2, '0, w);
      chk("t4_gap", w, (k == 0) ? 0 : 1);
    end
    p0_req_i = 1'b0; p1_req_i = 1'b0;
    chk("t4_p0_line3", p0_rdata_o, {8{32'hC0DE_0003}});
    chk("t4_p1_line5", p1_rdata_o, {8{32'hC0DE_0005}});

    // 5: memory never acks -> timeout in the 8th MEM cycle, busy held; reset clears
    do_reset();
    p0_addr_i = 32'h40; p0_req_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("t5_busy", {254'd0, busy_o, mem_enable_o}, 256'd3);
      chk("t5_timeout", {255'd0, timeout_o}, {255'd0, (k >= 8)});
    end
    p0_req_i = 1'b0; rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t5_rst_clear", {253'd0, timeout_o, busy_o, mem_enable_o}, 256'd0);

    // 6: reset during MEM aborts silently; stray mem_ack_i in IDLE is ignored
    tick();
    p1_addr_i = 32'h20; p1_write_i = 1'b0; p1_req_i = 1'b1;
    tick();
    tick();
    chk("t6_in_mem", {255'd0, mem_enable_o}, 256'd1);
    rst_i = 1'b1; p1_req_i = 1'b0;
    tick();
    rst_i = 1'b0;
    chk("t6_abort", {252'd0, busy_o, mem_enable_o, p0_ack_o, p1_ack_o}, 256'd0);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t6_stray_ack", {252'd0, busy_o, mem_enable_o, p0_ack_o, p1_ack_o}, 256'd0);
      tick();
    end
    p0_addr_i = 32'h60; p0_req_i = 1'b1;
    run_txn(1'b0, 1'b0, 32'h60, 1, '0, w);
    p0_req_i = 1'b0;
    chk("t6_recover", w, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
